// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg: register map, status bits and shared FSM state type
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_RXDATA = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_BAUD   = 4'hC;

  localparam int STAT_TX_READY  = 0;
  localparam int STAT_RX_VALID  = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FRAME_ERR = 3;

  localparam logic [15:0] BAUD_MIN = 16'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < BAUD_MIN) ? BAUD_MIN : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ------------------------------------------------------------------
// uart_rx: synchronised 8N1 receiver, one-cycle valid/frame-error pulses
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        valid,
  output logic        frame_err
);

  logic [1:0]  sync;
  logic        rx_s;
  logic        rx_prev;
  uart_state_t state;
  logic [15:0] cnt;
  logic [15:0] len;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  assign rx_s = sync[1];

  // Bit length is latched at every bit boundary so a BAUD change lands cleanly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= 16'd0;
      len       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rx_prev   <= rx_s;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_s) begin
            state <= ST_START;
            cnt   <= 16'd0;
            len   <= baud;
          end
        end
        ST_START: begin
          if (cnt == (len >> 1) - 16'd1) begin
            cnt     <= 16'd0;
            len     <= baud;
            bit_idx <= 3'd0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt == len - 16'd1) begin
            cnt   <= 16'd0;
            len   <= baud;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt == len - 16'd1) begin
            cnt   <= 16'd0;
            state <= ST_IDLE;
            if (rx_s) begin
              data  <= shift;
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_wbs.sv
// ------------------------------------------------------------------
// uart_wbs: Wishbone classic slave UART (8N1 TX/RX, programmable baud)
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_wbs
  import uart_pkg::*;
#(
  parameter int WISHBONE_ADDR_WIDTH = 32,
  parameter int WISHBONE_BUS_WIDTH  = 32,
  parameter int CLKS_PER_BIT        = 868
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wbs_cyc,
  input  logic                            wbs_stb,
  input  logic [WISHBONE_ADDR_WIDTH-1:0]  wbs_adr,
  input  logic                            wbs_we,
  input  logic [WISHBONE_BUS_WIDTH-1:0]   wbs_dat_i,
  input  logic [WISHBONE_BUS_WIDTH/8-1:0] wbs_sel,
  output logic [WISHBONE_BUS_WIDTH-1:0]   wbs_dat_o,
  output logic                            wbs_ack,
  output logic                            wbs_err,
  output logic                            uart_tx,
  input  logic                            uart_rx
);

  localparam int SEL_W = WISHBONE_BUS_WIDTH / 8;

  logic        req;
  logic [3:0]  off;
  logic        bad_adr;
  logic        acc_err;
  logic        do_write;
  logic        do_read;
  logic        tx_ready;
  logic        tx_load;
  logic        rd_rx;
  logic        w1c;
  logic        baud_we;
  logic [15:0] baud;
  logic [15:0] baud_wr;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        overrun;
  logic        frame_err;
  logic [7:0]  rx_byte;
  logic        rx_done;
  logic        rx_ferr;
  logic [WISHBONE_BUS_WIDTH-1:0] rd_word;

  uart_state_t tx_state;
  logic [15:0] tx_cnt;
  logic [15:0] tx_len;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_hold;
  logic [7:0]  tx_shift;
  logic        tx_full;

  logic unused;
  assign unused = ^{wbs_adr[WISHBONE_ADDR_WIDTH-1:16],
                    wbs_dat_i[WISHBONE_BUS_WIDTH-1:16],
                    wbs_sel[SEL_W-1:2]};

  assign req      = wbs_cyc & wbs_stb & ~wbs_ack & ~wbs_err;
  assign off      = wbs_adr[3:0];
  assign bad_adr  = (wbs_adr[1:0] != 2'b00) || (wbs_adr[15:4] != 12'h000);
  assign tx_ready = (tx_state == ST_IDLE) && !tx_full;

  always_comb begin
    acc_err = bad_adr;
    if (!bad_adr) begin
      case (off)
        REG_TXDATA: acc_err = !wbs_we || !tx_ready;
        REG_RXDATA: acc_err = wbs_we;
        default:    acc_err = 1'b0;
      endcase
    end
  end

  assign do_write = req & wbs_we & ~acc_err;
  assign do_read  = req & ~wbs_we & ~acc_err;
  assign tx_load  = do_write && (off == REG_TXDATA) && wbs_sel[0];
  assign rd_rx    = do_read && (off == REG_RXDATA);
  assign w1c      = do_write && (off == REG_STATUS) && wbs_sel[0];
  assign baud_we  = do_write && (off == REG_BAUD) && (wbs_sel[0] || wbs_sel[1]);

  always_comb begin
    baud_wr = baud;
    if (wbs_sel[0]) baud_wr[7:0]  = wbs_dat_i[7:0];
    if (wbs_sel[1]) baud_wr[15:8] = wbs_dat_i[15:8];
    baud_wr = clamp_baud(baud_wr);
  end

  always_comb begin
    rd_word = '0;
    case (off)
      REG_RXDATA: rd_word[7:0] = rx_data;
      REG_STATUS: begin
        rd_word[STAT_TX_READY]  = tx_ready;
        rd_word[STAT_RX_VALID]  = rx_valid;
        rd_word[STAT_OVERRUN]   = overrun;
        rd_word[STAT_FRAME_ERR] = frame_err;
      end
      REG_BAUD:   rd_word[15:0] = baud;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbs_ack   <= 1'b0;
      wbs_err   <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack   <= req & ~acc_err;
      wbs_err   <= req & acc_err;
      wbs_dat_o <= do_read ? rd_word : '0;
    end
  end

  // A byte completing on the same edge as an RXDATA read replaces, not overruns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud      <= 16'(CLKS_PER_BIT);
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (baud_we) baud <= baud_wr;
      if (rx_done && (!rx_valid || rd_rx)) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid && !rd_rx)
        overrun <= 1'b1;
      else if (w1c && wbs_dat_i[STAT_OVERRUN])
        overrun <= 1'b0;
      if (rx_ferr)
        frame_err <= 1'b1;
      else if (w1c && wbs_dat_i[STAT_FRAME_ERR])
        frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= 16'd0;
      tx_len   <= 16'd0;
      tx_bit   <= 3'd0;
      tx_hold  <= 8'd0;
      tx_shift <= 8'd0;
      tx_full  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_load) begin
            tx_hold <= wbs_dat_i[7:0];
            tx_full <= 1'b1;
          end else if (tx_full) begin
            tx_full  <= 1'b0;
            tx_shift <= tx_hold;
            tx_cnt   <= 16'd0;
            tx_len   <= baud;
            tx_state <= ST_START;
            uart_tx  <= 1'b0;
          end
        end
        ST_START: begin
          if (tx_cnt == tx_len - 16'd1) begin
            tx_cnt   <= 16'd0;
            tx_len   <= baud;
            tx_bit   <= 3'd0;
            tx_state <= ST_DATA;
            uart_tx  <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == tx_len - 16'd1) begin
            tx_cnt <= 16'd0;
            tx_len <= baud;
            if (tx_bit == 3'd7) begin
              tx_state <= ST_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_shift <= tx_shift >> 1;
              uart_tx  <= tx_shift[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_cnt == tx_len - 16'd1) begin
            tx_cnt   <= 16'd0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  uart_rx u_rx (
    .clk       (clk),
    .rst       (rst),
    .baud      (baud),
    .rx        (uart_rx),
    .data      (rx_byte),
    .valid     (rx_done),
    .frame_err (rx_ferr)
  );

endmodule

`default_nettype wire

// File: tb/tb_uart_wbs.sv
// ------------------------------------------------------------------
// tb_uart_wbs: scoreboarded directed bench for the Wishbone UART
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_wbs;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbs_cyc = 1'b0;
  logic        wbs_stb = 1'b0;
  logic [31:0] wbs_adr = 32'd0;
  logic        wbs_we = 1'b0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic [3:0]  wbs_sel = 4'd0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack;
  logic        wbs_err;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int passed = 0;
  int total  = 0;

  logic        exp_err_q[$];
  logic [31:0] exp_dat_q[$];
  string       exp_name_q[$];

  uart_wbs dut (
    .clk       (clk),
    .rst       (rst),
    .wbs_cyc   (wbs_cyc),
    .wbs_stb   (wbs_stb),
    .wbs_adr   (wbs_adr),
    .wbs_we    (wbs_we),
    .wbs_dat_i (wbs_dat_i),
    .wbs_sel   (wbs_sel),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack   (wbs_ack),
    .wbs_err   (wbs_err),
    .uart_tx   (uart_tx),
    .uart_rx   (uart_rx)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  task automatic monitor();
    logic        e;
    logic [31:0] d;
    string       n;
    forever begin
      @(negedge clk);
      if (!rst && (wbs_ack || wbs_err)) begin
        if (exp_err_q.size() == 0) begin
          check("unexpected_resp", {30'd0, wbs_err, wbs_ack}, 32'd0);
        end else begin
          e = exp_err_q.pop_front();
          d = exp_dat_q.pop_front();
          n = exp_name_q.pop_front();
          check({n, "_resp"}, {30'd0, wbs_err, wbs_ack}, {30'd0, e, ~e});
          check({n, "_data"}, wbs_dat_o, d);
        end
      end
    end
  endtask

  // Issues one transfer; expects ack/err exactly one cycle after the strobe.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                     input string name);
    exp_err_q.push_back(exp_err);
    exp_dat_q.push_back(exp_dat);
    exp_name_q.push_back(name);
    @(posedge clk); #1;
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
    wbs_adr = adr; wbs_dat_i = dat; wbs_sel = sel;
    @(posedge clk); #1;
    check({name, "_latency"}, {31'd0, wbs_ack | wbs_err}, 32'd1);
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    wbs_adr = 32'd0; wbs_dat_i = 32'd0; wbs_sel = 4'd0;
  endtask

  task automatic rd(input logic [3:0] o, input logic [31:0] exp, input string name);
    bus(1'b0, BASE | {28'd0, o}, 32'd0, 4'hF, 1'b0, exp, name);
  endtask

  task automatic wr(input logic [3:0] o, input logic [31:0] dat, input string name);
    bus(1'b1, BASE | {28'd0, o}, dat, 4'hF, 1'b0, 32'd0, name);
  endtask

  // Serial frame at BAUD = 4: start, 8 data bits LSB first, stop.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (4) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] frame;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_ack",     32'(wbs_ack), 32'd0);
    check("rst_err",     32'(wbs_err), 32'd0);
    check("rst_dat_o",   wbs_dat_o,    32'd0);

    rd(4'h8, 32'h1,   "rst_status");
    rd(4'hC, 32'd868, "rst_baud");

    // TX 0x55 at BAUD = 4 with a rejected second write during the start bit
    wr(4'hC, 32'd4, "baud_set4");
    wr(4'h0, 32'h55, "tx_write");
    bus(1'b1, BASE, 32'hFF, 4'hF, 1'b1, 32'd0, "tx_busy_write");
    frame = {1'b1, 8'h55, 1'b0};
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) begin
        repeat (4) @(posedge clk);
        #1;
      end
      check($sformatf("tx_bit%0d", k), 32'(uart_tx), 32'(frame[k]));
    end
    repeat (4) @(posedge clk);
    rd(4'h8, 32'h1, "tx_done_status");

    // RX single byte
    send_frame(8'hA3, 1'b1);
    repeat (8) @(posedge clk);
    rd(4'h8, 32'h3,  "rx1_status_valid");
    rd(4'h4, 32'hA3, "rx1_data");
    rd(4'h8, 32'h1,  "rx1_status_cleared");

    // RX overrun: second byte dropped, old byte kept
    send_frame(8'hA3, 1'b1);
    send_frame(8'h5C, 1'b1);
    repeat (8) @(posedge clk);
    rd(4'h4, 32'hA3, "ovr_data");
    rd(4'h8, 32'h5,  "ovr_status");
    wr(4'h8, 32'h4,  "ovr_w1c");
    rd(4'h8, 32'h1,  "ovr_status_cleared");

    // Framing error and glitch rejection
    send_frame(8'h12, 1'b0);
    repeat (8) @(posedge clk);
    rd(4'h8, 32'h9, "ferr_status");
    wr(4'h8, 32'h8, "ferr_w1c");
    rd(4'h8, 32'h1, "ferr_status_cleared");
    uart_rx = 1'b0;
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (50) @(posedge clk);
    rd(4'h8, 32'h1, "glitch_status");

    // Access errors and BAUD byte lanes / clamping
    bus(1'b0, BASE | 32'h2,  32'd0, 4'hF, 1'b1, 32'd0, "err_misaligned");
    bus(1'b0, BASE | 32'h10, 32'd0, 4'hF, 1'b1, 32'd0, "err_out_of_range");
    bus(1'b0, BASE,          32'd0, 4'hF, 1'b1, 32'd0, "err_read_txdata");
    bus(1'b1, BASE | 32'h4,  32'h7, 4'hF, 1'b1, 32'd0, "err_write_rxdata");
    bus(1'b1, BASE | 32'hC,  32'h0000_1234, 4'b0010, 1'b0, 32'd0, "baud_hi_lane");
    rd(4'hC, 32'h1204, "baud_hi_lane_rb");
    wr(4'hC, 32'd1, "baud_clamp_wr");
    rd(4'hC, 32'd4, "baud_clamp_rb");

    // Reset during TX data bit 3 with a pending RX byte
    send_frame(8'h77, 1'b1);
    repeat (8) @(posedge clk);
    wr(4'h0, 32'hF0, "tx2_write");
    repeat (19) @(posedge clk);
    #1;
    check("tx2_bit3_before_rst", 32'(uart_tx), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_tx_line", 32'(uart_tx), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(4'h8, 32'h1,   "rst2_status");
    rd(4'hC, 32'd868, "rst2_baud");

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(exp_err_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
